// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit.
package ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned INSTR_W = 32;

  // Primary opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

  // ALU function selects
  localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_ADDR,
    S_MEMRD,
    S_LWB,
    S_MEMWR,
    S_BEQ,
    S_ERR
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode/funct decode into an ALU select and a legality flag.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALU_W-1:0]   alu_sel,
  output logic               legal
);

  // Address arithmetic and addi use ADD; beq compares by subtraction
  always_comb begin
    alu_sel = ALU_ADD;
    legal   = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADD:  begin alu_sel = ALU_ADD; legal = 1'b1; end
          FN_SUB:  begin alu_sel = ALU_SUB; legal = 1'b1; end
          FN_AND:  begin alu_sel = ALU_AND; legal = 1'b1; end
          FN_OR:   begin alu_sel = ALU_OR;  legal = 1'b1; end
          FN_SLT:  begin alu_sel = ALU_SLT; legal = 1'b1; end
          default: begin alu_sel = ALU_ADD; legal = 1'b0; end
        endcase
      end
      OP_LW, OP_SW, OP_ADDI: begin
        alu_sel = ALU_ADD;
        legal   = 1'b1;
      end
      OP_BEQ: begin
        alu_sel = ALU_SUB;
        legal   = 1'b1;
      end
      default: begin
        alu_sel = ALU_ADD;
        legal   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: latches one instruction, sequences the datapath
// controls state by state and counts retired instructions.
module mc_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [INSTR_W-1:0] ir,
  input  logic               iszero,
  output logic [ALU_W-1:0]   alu_control,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUsrc,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               MemToReg,
  output logic               branch_taken,
  output logic               done,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_count
);

  state_t               state_q;
  state_t               state_d;
  logic [INSTR_W-1:0]   ir_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [OP_W-1:0]      op;
  logic [FUNCT_W-1:0]   funct;
  logic [ALU_W-1:0]     dec_alu;
  logic                 dec_legal;
  logic                 is_rtype;

  assign op          = ir_q[31:26];
  assign funct       = ir_q[5:0];
  assign is_rtype    = (op == OP_RTYPE);
  assign ir          = ir_q;
  assign instr_count = cnt_q;

  alu_decoder u_alu_decoder (
    .op      (op),
    .funct   (funct),
    .alu_sel (dec_alu),
    .legal   (dec_legal)
  );

  // State, instruction register and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && instr_valid) begin
        ir_q <= instr;
      end
      if (done) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state sequencing and Moore control decode from the current state
  always_comb begin
    state_d      = state_q;
    instr_ready  = 1'b0;
    alu_control  = ALU_ADD;
    RegDst       = 1'b0;
    RegWrite     = 1'b0;
    ALUsrc       = 1'b0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    MemToReg     = 1'b0;
    branch_taken = 1'b0;
    done         = 1'b0;
    illegal      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!dec_legal)                    state_d = S_ERR;
        else if (op == OP_LW || op == OP_SW) state_d = S_ADDR;
        else if (op == OP_BEQ)             state_d = S_BEQ;
        else                               state_d = S_EXEC;
      end
      S_EXEC: begin
        RegDst      = is_rtype;
        ALUsrc      = !is_rtype;
        alu_control = dec_alu;
        state_d     = S_WB;
      end
      S_WB: begin
        RegDst      = is_rtype;
        ALUsrc      = !is_rtype;
        alu_control = dec_alu;
        RegWrite    = 1'b1;
        done        = 1'b1;
        state_d     = S_IDLE;
      end
      S_ADDR: begin
        ALUsrc  = 1'b1;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ALUsrc  = 1'b1;
        MemRead = 1'b1;
        state_d = S_LWB;
      end
      S_LWB: begin
        ALUsrc   = 1'b1;
        MemRead  = 1'b1;
        MemToReg = 1'b1;
        RegWrite = 1'b1;
        done     = 1'b1;
        state_d  = S_IDLE;
      end
      S_MEMWR: begin
        ALUsrc   = 1'b1;
        MemWrite = 1'b1;
        done     = 1'b1;
        state_d  = S_IDLE;
      end
      S_BEQ: begin
        alu_control  = ALU_SUB;
        branch_taken = iszero;
        done         = 1'b1;
        state_d      = S_IDLE;
      end
      S_ERR: begin
        illegal = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
